// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 bridge.
// Contains the FSM state set, the fixed AXI field values, the default IDs and an address-alignment helper.
package sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4
  } state_t;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [3:0] ID_INST_DEF = 4'd0;
  localparam logic [3:0] ID_DATA_DEF = 4'd1;

  // Every transfer is a single full word, so the byte offset is dropped on the bus.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Converts the core's instruction and data SRAM ports into one AXI3 master.
// One transaction is in flight at a time, data accesses take priority, and the core stalls while any enabled access is outstanding.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEF,
  parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,

  output logic        stallreq_bus,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic        bvalid,
  output logic        bready
);

  state_t      state_q, state_d;

  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_wstrb_q;
  logic [3:0]  req_id_q;

  logic        inst_done_q, data_done_q;
  logic        aw_ok_q, w_ok_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic        data_pending, inst_pending;
  logic        latch_req;
  logic [31:0] sel_addr;
  logic [3:0]  sel_id;
  logic [3:0]  sel_wstrb;

  // The slave returns responses in order with one transaction outstanding, so rid carries no extra information.
  logic        unused_rid;
  assign unused_rid = ^rid;

  assign data_pending = data_sram_en & ~data_done_q;
  assign inst_pending = inst_sram_en & ~inst_done_q;
  assign stallreq_bus = data_pending | inst_pending;

  assign sel_addr  = data_pending ? data_sram_addr : inst_sram_addr;
  assign sel_id    = data_pending ? ID_DATA : ID_INST;
  assign sel_wstrb = data_pending ? data_sram_wen : 4'b0000;

  assign arid    = req_id_q;
  assign araddr  = req_addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = req_id_q;
  assign awaddr  = req_addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = 4'd0;
  assign wdata   = req_wdata_q;
  assign wstrb   = req_wstrb_q;
  assign wlast   = 1'b1;

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  // Next state and channel handshakes; valids derive only from state and per-channel completion flags.
  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_pending) begin
          latch_req = 1'b1;
          state_d   = (data_sram_wen == 4'b0000) ? RD_AR : WR_AWW;
        end else if (inst_pending) begin
          latch_req = 1'b1;
          state_d   = RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) state_d = IDLE;
      end
      WR_AWW: begin
        awvalid = ~aw_ok_q;
        wvalid  = ~w_ok_q;
        if ((aw_ok_q | awready) & (w_ok_q | wready)) state_d = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, request capture, response capture and done-flag bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_addr_q   <= 32'h0;
      req_wdata_q  <= 32'h0;
      req_wstrb_q  <= 4'h0;
      req_id_q     <= 4'h0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;

      if (latch_req) begin
        req_addr_q  <= word_align(sel_addr);
        req_wdata_q <= data_sram_wdata;
        req_wstrb_q <= sel_wstrb;
        req_id_q    <= sel_id;
      end

      if (state_q != WR_AWW) begin
        aw_ok_q <= 1'b0;
        w_ok_q  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_ok_q <= 1'b1;
        if (wvalid && wready)   w_ok_q  <= 1'b1;
      end

      // A cycle without stall means the core consumed its results, so the next request starts fresh.
      if (!stallreq_bus) begin
        inst_done_q <= 1'b0;
        data_done_q <= 1'b0;
      end

      if (state_q == RD_R && rvalid) begin
        if (req_id_q == ID_DATA) begin
          data_rdata_q <= rdata;
          data_done_q  <= 1'b1;
        end else begin
          inst_rdata_q <= rdata;
          inst_done_q  <= 1'b1;
        end
      end

      if (state_q == WR_B && bvalid) data_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: a core-side driver, a memory-backed AXI slave and a negedge monitor.
// Expected read data comes from a word-array reference model; AXI address and data beats are checked against queued expectations.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        stallreq_bus;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'h0;
  logic [31:0] rdata = 32'h0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic        bready;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .stallreq_bus(stallreq_bus),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        chk_inst;
    logic [31:0] inst_val;
    logic        chk_data;
    logic [31:0] data_val;
  } rsp_t;
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } addr_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } wbeat_t;

  rsp_t   rsp_q[$];
  addr_t  ar_q[$];
  addr_t  aw_q[$];
  wbeat_t w_q[$];

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] slv_mem [int unsigned];

  bit fast_mode = 1'b1;
  bit r_hold = 1'b0;
  int aw_hold_n = 0;
  int awv_cycles = 0;
  int wv_cycles = 0;
  int w_beats = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic finishRun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  function automatic logic [31:0] initWord(input int unsigned widx);
    return (widx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] addr);
    int unsigned widx = addr >> 2;
    return ref_mem.exists(widx) ? ref_mem[widx] : initWord(widx);
  endfunction

  function automatic void refWrite(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] w = refRead(addr);
    for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[addr >> 2] = w;
  endfunction

  function automatic logic [31:0] slvRead(input logic [31:0] addr);
    int unsigned widx = addr >> 2;
    return slv_mem.exists(widx) ? slv_mem[widx] : initWord(widx);
  endfunction

  function automatic void slvWrite(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] w = slvRead(addr);
    for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
    slv_mem[addr >> 2] = w;
  endfunction

  // Issue one core request, hold it while stalled, and return the number of stalled cycles.
  task automatic applyStimulus(input logic ien, input logic [31:0] iaddr, input logic den,
                               input logic [3:0] dwen, input logic [31:0] daddr,
                               input logic [31:0] dwdata, output int stall_cycles);
    rsp_t r;
    r.chk_inst = 1'b0; r.inst_val = 32'h0; r.chk_data = 1'b0; r.data_val = 32'h0;
    if (den) begin
      if (dwen == 4'h0) begin
        ar_q.push_back('{id: 4'd1, addr: {daddr[31:2], 2'b00}});
        r.chk_data = 1'b1;
        r.data_val = refRead(daddr);
      end else begin
        aw_q.push_back('{id: 4'd1, addr: {daddr[31:2], 2'b00}});
        w_q.push_back('{data: dwdata, strb: dwen});
        refWrite(daddr, dwdata, dwen);
      end
    end
    if (ien) begin
      ar_q.push_back('{id: 4'd0, addr: {iaddr[31:2], 2'b00}});
      r.chk_inst = 1'b1;
      r.inst_val = refRead(iaddr);
    end
    rsp_q.push_back(r);
    inst_sram_en = ien;  inst_sram_addr = iaddr;
    data_sram_en = den;  data_sram_wen = dwen;
    data_sram_addr = daddr;  data_sram_wdata = dwdata;
    stall_cycles = 0;
    forever begin
      @(negedge clk);
      if (!stallreq_bus) break;
      stall_cycles++;
      if (stall_cycles > 400) begin
        checkOutput("stall_timeout", 64'(stall_cycles), 64'd400);
        finishRun();
      end
    end
    @(posedge clk);
    #1;
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
  endtask

  // Memory-backed AXI slave: samples handshakes at negedge, drives its outputs just after posedge.
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, cap_rst;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_arid, cap_wstrb;
    bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
    int r_cnt = 0, b_cnt = 0, aw_wait = 0;
    logic [31:0] r_addr = 0, s_awaddr = 0, s_wdata = 0;
    logic [3:0]  r_id = 0, s_wstrb = 0;
    forever begin
      @(negedge clk);
      cap_rst = rst;
      ar_hs = arvalid && arready;  cap_araddr = araddr;  cap_arid = arid;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;  cap_awaddr = awaddr;
      w_hs  = wvalid && wready;    cap_wdata = wdata;  cap_wstrb = wstrb;
      b_hs  = bvalid && bready;
      if (awvalid && !awready) aw_wait++;
      @(posedge clk);
      #1;
      if (cap_rst) begin
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; aw_wait = 0;
        rvalid = 0; bvalid = 0; arready = 0; awready = 0; wready = 0;
        continue;
      end
      if (ar_hs) begin
        r_pend = 1; r_addr = cap_araddr; r_id = cap_arid;
        r_cnt = fast_mode ? 0 : $urandom_range(0, 3);
      end
      if (r_hs) rvalid = 0;
      if (r_pend && !rvalid && !r_hold) begin
        if (r_cnt == 0) begin
          rvalid = 1; rdata = slvRead(r_addr); rid = r_id; r_pend = 0;
        end else r_cnt--;
      end
      if (aw_hs) begin aw_got = 1; s_awaddr = cap_awaddr; aw_wait = 0; end
      if (w_hs)  begin w_got = 1; s_wdata = cap_wdata; s_wstrb = cap_wstrb; end
      if (aw_got && w_got) begin
        slvWrite(s_awaddr, s_wdata, s_wstrb);
        aw_got = 0; w_got = 0; b_pend = 1;
        b_cnt = fast_mode ? 0 : $urandom_range(0, 3);
      end
      if (b_hs) bvalid = 0;
      if (b_pend && !bvalid) begin
        if (b_cnt == 0) begin bvalid = 1; b_pend = 0; end
        else b_cnt--;
      end
      arready = fast_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
      wready  = fast_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (aw_hold_n > 0) awready = (aw_wait >= aw_hold_n - 1);
      else awready = fast_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT releases the stall or completes an AXI handshake.
  initial begin
    rsp_t r;
    addr_t a;
    wbeat_t wb;
    forever begin
      @(negedge clk);
      if (awvalid) awv_cycles++;
      if (wvalid)  wv_cycles++;
      if (!rst) begin
        if (!stallreq_bus && (inst_sram_en || data_sram_en)) begin
          if (rsp_q.size() == 0) checkOutput("rsp_unexpected", 64'd1, 64'd0);
          else begin
            r = rsp_q.pop_front();
            if (r.chk_inst) checkOutput("inst_rdata", 64'(inst_sram_rdata), 64'(r.inst_val));
            if (r.chk_data) checkOutput("data_rdata", 64'(data_sram_rdata), 64'(r.data_val));
          end
        end
        if (arvalid && arready) begin
          if (ar_q.size() == 0) checkOutput("ar_unexpected", 64'd1, 64'd0);
          else begin
            a = ar_q.pop_front();
            checkOutput("ar_id_addr", {28'h0, arid, araddr}, {28'h0, a.id, a.addr});
            checkOutput("ar_fixed", 64'({arlen, arsize, arburst, arlock, arcache, arprot}),
                        64'({4'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0}));
          end
        end
        if (awvalid && awready) begin
          if (aw_q.size() == 0) checkOutput("aw_unexpected", 64'd1, 64'd0);
          else begin
            a = aw_q.pop_front();
            checkOutput("aw_id_addr", {28'h0, awid, awaddr}, {28'h0, a.id, a.addr});
            checkOutput("aw_fixed", 64'({awlen, awsize, awburst, awlock, awcache, awprot}),
                        64'({4'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0}));
          end
        end
        if (wvalid && wready) begin
          w_beats++;
          if (w_q.size() == 0) checkOutput("w_unexpected", 64'd1, 64'd0);
          else begin
            wb = w_q.pop_front();
            checkOutput("w_beat", {27'h0, wlast, wstrb, wdata}, {27'h0, 1'b1, wb.strb, wb.data});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    checkOutput("global_timeout", 64'd1, 64'd0);
    finishRun();
  end

  int cyc;
  int beats0;
  int wait_n;
  logic ien_r, den_r;
  logic [3:0] wen_r;
  logic [31:0] iaddr_r, daddr_r, wdata_r;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", 64'({stallreq_bus, arvalid, rready, awvalid, wvalid, bready}), 64'd0);
    checkOutput("reset_rdata", {inst_sram_rdata, data_sram_rdata}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    fast_mode = 1'b1;
    applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, cyc);
    checkOutput("read_latency", 64'(cyc), 64'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_0012, 32'h0000_BEEF, cyc);
    checkOutput("write_latency", 64'(cyc), 64'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 32'h8000_0010, 32'h0, cyc);
    applyStimulus(1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_0010, 32'h0, cyc);
    checkOutput("dual_latency", 64'(cyc), 64'd6);
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 4'h0, 32'h0, 32'h0, cyc);
    applyStimulus(1'b1, 32'h0000_0004, 1'b0, 4'h0, 32'h0, 32'h0, cyc);
    checkOutput("back_to_back_latency", 64'(cyc), 64'd3);

    aw_hold_n = 5;
    awv_cycles = 0;
    wv_cycles = 0;
    beats0 = w_beats;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b1100, 32'h8000_0020, 32'hCAFE_0000, cyc);
    checkOutput("awvalid_cycles", 64'(awv_cycles), 64'd5);
    checkOutput("wvalid_cycles", 64'(wv_cycles), 64'd1);
    checkOutput("w_beat_count", 64'(w_beats - beats0), 64'd1);
    aw_hold_n = 0;

    r_hold = 1'b1;
    ar_q.push_back('{id: 4'd0, addr: 32'h0000_1000});
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'h0000_1000;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!rready && wait_n < 50);
    checkOutput("reach_rd_r", 64'(rready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    inst_sram_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_reset_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, stallreq_bus}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r_hold = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 4'h0, 32'h0, 32'h0, cyc);
    checkOutput("post_reset_latency", 64'(cyc), 64'd3);

    fast_mode = 1'b0;
    for (int i = 0; i < 150; i++) begin
      ien_r = $urandom_range(0, 1);
      den_r = $urandom_range(0, 1);
      if (!ien_r && !den_r) ien_r = 1'b1;
      wen_r = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0;
      iaddr_r = 32'h8000_0000 + 32'($urandom_range(0, 15)) * 4;
      daddr_r = 32'h8000_0000 + 32'($urandom_range(0, 63));
      wdata_r = $urandom;
      applyStimulus(ien_r, iaddr_r, den_r, wen_r, daddr_r, wdata_r, cyc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("queues_drained", 64'(rsp_q.size() + ar_q.size() + aw_q.size() + w_q.size()), 64'd0);
    finishRun();
  end

endmodule
